// File: rtl/seq_signed_divider_pkg.sv
// Shared widths, FSM encoding and saturation constants for the sequential signed divider.
package seq_signed_divider_pkg;

    localparam int N     = 12;
    localparam int ITERS = 2 * N;
    localparam int CNT_W = $clog2(ITERS) + 1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

    // Largest quotient magnitudes that still fit an N-bit signed result.
    localparam logic [2*N-1:0] QMAX_POS = (2*N)'((1 << (N-1)) - 1);
    localparam logic [2*N-1:0] QMAX_NEG = (2*N)'(1 << (N-1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_signed_divider_twos_abs_neg.sv
// Conditional two's-complement negation: used for both magnitude extraction and sign application.
module seq_signed_divider_twos_abs_neg #(
    parameter int W = 8
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_out
);

    assign o_out = i_neg ? -i_in : i_in;

endmodule

// File: rtl/seq_signed_divider.sv
// Radix-2 restoring signed divider: 2N-bit dividend / N-bit divisor, truncating (C) semantics.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   a,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     q,
    output logic [N-1:0]     r,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;

    logic [2*N-1:0]   r_dvd;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_bmag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;

    logic [N-1:0]     r_quot;
    logic [N-1:0]     r_rmdr;
    logic             r_div_zero;
    logic             r_ovf;

    logic [2*N-1:0]   w_amag;
    logic [N-1:0]     w_bmag;
    logic [N:0]       w_shift;
    logic [N:0]       w_trial;
    logic             w_qbit;
    logic             w_accept;
    logic             w_b_zero;
    logic             w_last;
    logic             w_ovf;
    logic [N-1:0]     w_r_in;
    logic [N-1:0]     w_q_signed;
    logic [N-1:0]     w_r_signed;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_b_zero = (b == '0);
    assign w_last   = (r_cnt == LAST_ITER);

    // The dividend register shifts left each step and collects quotient bits at the LSB.
    assign w_shift = {r_rem, r_dvd[2*N-1]};
    assign w_trial = w_shift - {1'b0, r_bmag};
    assign w_qbit  = ~w_trial[N];

    assign w_ovf = r_sign_q ? (r_dvd > QMAX_NEG) : (r_dvd > QMAX_POS);

    // On divide-by-zero r_dvd still holds |a|; negating it back recovers a[N-1:0].
    assign w_r_in = r_dz ? r_dvd[N-1:0] : r_rem;

    seq_signed_divider_twos_abs_neg #(.W(2*N)) u_abs_a (
        .i_neg (a[2*N-1]),
        .i_in  (a),
        .o_out (w_amag)
    );

    seq_signed_divider_twos_abs_neg #(.W(N)) u_abs_b (
        .i_neg (b[N-1]),
        .i_in  (b),
        .o_out (w_bmag)
    );

    seq_signed_divider_twos_abs_neg #(.W(N)) u_sign_q (
        .i_neg (r_sign_q),
        .i_in  (r_dvd[N-1:0]),
        .o_out (w_q_signed)
    );

    seq_signed_divider_twos_abs_neg #(.W(N)) u_sign_r (
        .i_neg (r_sign_r),
        .i_in  (w_r_in),
        .o_out (w_r_signed)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_state <= w_b_zero ? FIX : CALC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: these are ordinary flops rather than a memory, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd      <= '0;
            r_rem      <= '0;
            r_bmag     <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
            r_quot     <= '0;
            r_rmdr     <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_dvd    <= w_amag;
            r_bmag   <= w_bmag;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_q <= a[2*N-1] ^ b[N-1];
            r_sign_r <= a[2*N-1];
            r_dz     <= w_b_zero;
        end else if (r_state == CALC) begin
            r_dvd <= {r_dvd[2*N-2:0], w_qbit};
            r_rem <= w_qbit ? w_trial[N-1:0] : w_shift[N-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == FIX) begin
            if (r_dz) begin
                r_quot     <= r_sign_r ? SAT_NEG : SAT_POS;
                r_rmdr     <= w_r_signed;
                r_div_zero <= 1'b1;
                r_ovf      <= 1'b0;
            end else if (w_ovf) begin
                r_quot     <= r_sign_q ? SAT_NEG : SAT_POS;
                r_rmdr     <= '0;
                r_div_zero <= 1'b0;
                r_ovf      <= 1'b1;
            end else begin
                r_quot     <= w_q_signed;
                r_rmdr     <= w_r_signed;
                r_div_zero <= 1'b0;
                r_ovf      <= 1'b0;
            end
        end
    end

    assign q        = r_quot;
    assign r        = r_rmdr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: reset, sign cases, saturation, divide-by-zero, handshake, round trip.
module tb_seq_signed_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] a;
    logic [11:0] b;
    logic [11:0] q;
    logic [11:0] r;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        ovf;

    int n_tests;
    int n_fail;
    int lat;
    int n_done;
    logic [11:0] snap_q;
    logic        snap_busy;
    logic        snap_poke_busy;
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [23:0] p;

    seq_signed_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present operands with start high for the next edge.
    task automatic start_op(input logic [23:0] ta, input logic [11:0] tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
    endtask

    // Counts edges from the accepting edge (cycle 1) until done; optionally pokes start mid-op.
    task automatic wait_done(input int poke_at, output int cyc);
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start     = 1'b0;
        snap_q    = q;
        snap_busy = busy;
        while (!done && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == poke_at) begin
                snap_poke_busy = busy;
                a     = 24'd1;
                b     = 12'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        snap_poke_busy = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_q", {20'd0, q}, 32'd0);
        check("rst_r", {20'd0, r}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // -672 / -12 = 56 r 0
        start_op(24'hFFFD60, 12'hFF4);
        wait_done(-1, lat);
        check("m672_q", {20'd0, q}, 32'd56);
        check("m672_r", {20'd0, r}, 32'd0);
        check("m672_ovf", {31'd0, ovf}, 32'd0);
        check("m672_lat", lat, 32'd26);
        check("m672_busy_in_done", {31'd0, busy}, 32'd0);
        check("m672_busy_calc", {31'd0, snap_busy}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        start_op(24'd100, 12'd7);
        wait_done(-1, lat);
        check("p100_p7_q", {20'd0, q}, 32'd14);
        check("p100_p7_r", {20'd0, r}, 32'd2);

        start_op(-24'sd100, 12'd7);
        wait_done(-1, lat);
        check("m100_p7_q", {20'd0, q}, 32'hFF2);
        check("m100_p7_r", {20'd0, r}, 32'hFFE);

        start_op(24'd100, -12'sd7);
        wait_done(-1, lat);
        check("p100_m7_q", {20'd0, q}, 32'hFF2);
        check("p100_m7_r", {20'd0, r}, 32'd2);

        start_op(24'd4096, 12'd1);
        wait_done(-1, lat);
        check("ovf_pos_flag", {31'd0, ovf}, 32'd1);
        check("ovf_pos_q", {20'd0, q}, 32'h7FF);
        check("ovf_pos_r", {20'd0, r}, 32'd0);
        check("ovf_pos_dz", {31'd0, div_zero}, 32'd0);

        start_op(-24'sd2048, 12'd1);
        wait_done(-1, lat);
        check("minq_q", {20'd0, q}, 32'h800);
        check("minq_ovf", {31'd0, ovf}, 32'd0);
        check("minq_r", {20'd0, r}, 32'd0);

        start_op(24'h800000, 12'hFFF);
        wait_done(-1, lat);
        check("mina_ovf", {31'd0, ovf}, 32'd1);
        check("mina_q", {20'd0, q}, 32'h7FF);

        start_op(-24'sd5, 12'd0);
        wait_done(-1, lat);
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        check("dz_ovf", {31'd0, ovf}, 32'd0);
        check("dz_q", {20'd0, q}, 32'h800);
        check("dz_r", {20'd0, r}, 32'hFFB);
        check("dz_lat", lat, 32'd2);

        // start mid-CALC must be ignored: 1000 / 9 = 111 r 1
        start_op(24'd1000, 12'd9);
        wait_done(6, lat);
        check("busy_poke_busy", {31'd0, snap_poke_busy}, 32'd1);
        check("busy_poke_q", {20'd0, q}, 32'd111);
        check("busy_poke_r", {20'd0, r}, 32'd1);
        check("busy_poke_lat", lat, 32'd26);

        // start in the DONE cycle: 200 / -9 = -22 r 2
        start_op(24'd200, -12'sd9);
        wait_done(-1, lat);
        check("b2b_old_q_held", {20'd0, snap_q}, 32'd111);
        check("b2b_busy", {31'd0, snap_busy}, 32'd1);
        check("b2b_q", {20'd0, q}, 32'hFEA);
        check("b2b_r", {20'd0, r}, 32'd2);
        check("b2b_lat", lat, 32'd26);

        // Reset in the middle of CALC aborts the operation
        start_op(24'd1000, 12'd9);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_q", {20'd0, q}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        n_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        start_op(24'd100, 12'd7);
        wait_done(-1, lat);
        check("after_abort_q", {20'd0, q}, 32'd14);
        check("after_abort_r", {20'd0, r}, 32'd2);
        check("after_abort_lat", lat, 32'd26);

        // Round trip: (x*y)/y must give back x exactly
        for (int i = 0; i < 200; i++) begin
            x = 12'($urandom);
            y = 12'($urandom);
            if (y == 12'sd0) y = 12'sd1;
            p = x * y;
            start_op(p, y);
            wait_done(-1, lat);
            check("roundtrip", {7'd0, ovf, r, q}, {7'd0, 1'b0, 12'd0, x});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
